pipe_stage_reg: RTL
===================

// Module: pipe_stage_reg
// PURPOSE
//  Parametrised pipeline-boundary register carrying LANES {pc, insn} slots from one stage to the next (first use: IF->ID).
//  Ready/valid handshake on both sides, with a 2-entry skid so in_ready is a registered signal.
//  Synchronous flush inserts a bubble whose instruction is the control-zero NOP (all control signals 0).
//  Downstream stall (hazard) is out_ready=0; the held slot is never overwritten.
// PARAMETERS
//  LANES     1             instruction slots per beat (fetch width)
//  PC_W      32            pc width per lane
//  INSN_W    32            instruction width per lane
//  NOP_INSN  32'hFC000000  bubble instruction; decodes to all-zero control
// PORTS
//  clk           in   1              rising-edge clock
//  rst_n         in   1              asynchronous reset, active low
//  flush         in   1              kill all held and incoming slots this cycle
//  in_valid      in   1              upstream beat valid
//  in_ready      out  1              stage can accept a beat (registered)
//  in_lane_vld   in   LANES          per-lane valid within the beat
//  in_pc         in   LANES*PC_W     lane i at [i*PC_W +: PC_W]
//  in_insn       in   LANES*INSN_W   lane i at [i*INSN_W +: INSN_W]
//  out_valid     out  1              downstream beat valid
//  out_ready     in   1              downstream accepts; 0 = hazard stall
//  out_lane_vld  out  LANES          0 for every lane while out_valid=0
//  out_pc        out  LANES*PC_W     held pc of head entry
//  out_insn      out  LANES*INSN_W   head insn; NOP_INSN on invalid lanes or when empty
// BEHAVIOUR
//  - Reset (async, rst_n=0): state EMPTY; in_ready=1, out_valid=0, out_lane_vld=0, out_pc=0, every out_insn lane=NOP_INSN.
//  - Entries: MAIN (drives outputs) and SKID. States: EMPTY, ONE (MAIN full), TWO (both full).
//  - acc_in = in_valid & in_ready; acc_out = out_valid & out_ready. in_ready = (state!=TWO); out_valid = (state!=EMPTY).
//  - EMPTY: acc_in -> load MAIN, ONE.
//  - ONE: acc_in&acc_out -> MAIN<=in, stay ONE; acc_in only -> SKID<=in, TWO; acc_out only -> EMPTY.
//  - TWO: acc_out -> MAIN<=SKID, ONE; no new beat accepted (in_ready=0).
//  - Latency: beat accepted at edge N appears on out_* after edge N (1 cycle) when MAIN is free; throughput 1 beat/cycle with out_ready=1.
//  - Stall (out_ready=0): MAIN held bit-exact; 2nd beat goes to SKID; in_ready drops the cycle after SKID fills.
//  - Flush: highest priority; at the edge, state->EMPTY, both entries invalidated, the concurrent in_valid beat is dropped
//    (not accepted even though in_ready may be 1); out_insn lanes->NOP_INSN, out_pc keeps its previous value.
//  - Lane with in_lane_vld=0 is stored with insn NOP_INSN regardless of in_insn; its pc is still stored.
//  - in_valid=1 with in_lane_vld all 0 is a legal beat (all-bubble), accepted normally.
//  - Invalid outputs (out_valid=0): out_lane_vld=0, out_insn=NOP, out_pc stable.
//  - rst_n asserted mid-stall or mid-flush: immediate return to reset values; no payload survives.
// CONFIGURATION
//  - PIPE_STAGE_STATS_EN defined: adds out ports stall_cnt[31:0] (cycles with out_valid&!out_ready)
//    and flush_cnt[31:0] (cycles with flush=1); both saturate at 32'hFFFFFFFF; async-reset to 0.
//  - Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  - Shared package pipe_pkg: NOP_INSN default constant, state enum {EMPTY, ONE, TWO} (2-bit encoding).
//  - One sub-module pipe_stage_entry: LANES-wide payload register {lane_vld, pc, insn} with load enable
//    and NOP masking of invalid lanes; instantiated twice (MAIN, SKID). FSM and handshake in the top.
// TESTING
//  - Reset: rst_n=0 -> in_ready=1, out_valid=0, out_pc=0, out_insn=32'hFC000000 on every lane.
//  - Stream: out_ready=1, beats pc=0x00,0x04,0x08 on 3 cycles -> out_pc 0x00,0x04,0x08 on following 3 cycles, no gaps.
//  - Stall: pc=0x10 in MAIN, out_ready=0, send pc=0x14 -> in_ready=0 next cycle, out_pc stays 0x10;
//    out_ready=1 -> 0x10 then 0x14, in_ready returns 1.
//  - Flush with concurrent beat: state TWO, flush=1 and in_valid=1 pc=0x20 -> out_valid=0, insn=NOP, 0x20 never appears.
//  - LANES=2, in_lane_vld=2'b01, in_insn lane1=0x12345678 -> out_lane_vld=2'b01, out lane1 insn=32'hFC000000.
//  - STATS_EN build: 5 stall cycles + 2 flush cycles -> stall_cnt=5, flush_cnt=2; forced 32'hFFFFFFFF preload stays saturated.

Source files
------------

// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipeline-boundary register family.
//   NOP_INSN_DEFAULT : bubble instruction, decodes to all-zero control
//   stage_state_e    : occupancy of a two-entry stage (EMPTY / ONE / TWO)
// Optional feature macro used by pipe_stage_reg: PIPE_STAGE_STATS_EN
// ---------------------------------------------------------------------------
package pipe_pkg;

    localparam logic [31:0] NOP_INSN_DEFAULT = 32'hFC000000;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stage_state_e;

endpackage

// File: rtl/pipe_stage_entry.sv
// ---------------------------------------------------------------------------
// pipe_stage_entry
// One LANES-wide payload slot {lane_vld, pc, insn} with a load enable.
// Lanes presented with d_lane_vld=0 are stored with NOP_INSN so the
// downstream decoder sees a harmless bubble; their pc is still captured.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   load                capture d_* on the rising edge
//   d_lane_vld/pc/insn  incoming payload
//   q_lane_vld/pc/insn  stored payload
// ---------------------------------------------------------------------------
module pipe_stage_entry
    import pipe_pkg::*;
#(
    parameter int               LANES    = 1,
    parameter int               PC_W     = 32,
    parameter int               INSN_W   = 32,
    parameter logic [INSN_W-1:0] NOP_INSN = NOP_INSN_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic [LANES-1:0]          d_lane_vld,
    input  logic [LANES*PC_W-1:0]     d_pc,
    input  logic [LANES*INSN_W-1:0]   d_insn,
    output logic [LANES-1:0]          q_lane_vld,
    output logic [LANES*PC_W-1:0]     q_pc,
    output logic [LANES*INSN_W-1:0]   q_insn
);

    logic [LANES*INSN_W-1:0] masked_insn;

    // Replace the instruction of every invalid lane with the bubble.
    always_comb begin
        masked_insn = d_insn;
        for (int i = 0; i < LANES; i++) begin
            if (!d_lane_vld[i]) begin
                masked_insn[i*INSN_W +: INSN_W] = NOP_INSN;
            end
        end
    end

    // Payload register; holds its contents bit-exact whenever load is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_lane_vld <= '0;
            q_pc       <= '0;
            q_insn     <= {LANES{NOP_INSN}};
        end else if (load) begin
            q_lane_vld <= d_lane_vld;
            q_pc       <= d_pc;
            q_insn     <= masked_insn;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
// Pipeline-boundary register carrying LANES {pc, insn} slots between stages
// with ready/valid on both sides. A MAIN entry drives the outputs and a SKID
// entry absorbs one extra beat so in_ready can come straight from a flop.
// flush kills everything held and the beat offered in the same cycle.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   flush                            synchronous kill of all slots
//   in_valid/in_ready                upstream handshake (in_ready registered)
//   in_lane_vld/in_pc/in_insn        upstream payload, lane i at [i*W +: W]
//   out_valid/out_ready              downstream handshake (out_ready=0 stalls)
//   out_lane_vld/out_pc/out_insn     head payload; NOP/zero lanes when empty
// Optional (macro PIPE_STAGE_STATS_EN):
//   stall_cnt, flush_cnt             saturating event counters
// ---------------------------------------------------------------------------
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int               LANES    = 1,
    parameter int               PC_W     = 32,
    parameter int               INSN_W   = 32,
    parameter logic [INSN_W-1:0] NOP_INSN = NOP_INSN_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES-1:0]          in_lane_vld,
    input  logic [LANES*PC_W-1:0]     in_pc,
    input  logic [LANES*INSN_W-1:0]   in_insn,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES-1:0]          out_lane_vld,
    output logic [LANES*PC_W-1:0]     out_pc,
    output logic [LANES*INSN_W-1:0]   out_insn
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [31:0]               stall_cnt,
    output logic [31:0]               flush_cnt
`endif
);

    stage_state_e state_q, state_d;
    logic         in_ready_q;
    logic         acc_in, acc_out;
    logic         load_main, load_skid, main_from_skid;

    logic [LANES-1:0]        main_lane_vld, skid_lane_vld, main_d_lane_vld;
    logic [LANES*PC_W-1:0]   main_pc, skid_pc, main_d_pc;
    logic [LANES*INSN_W-1:0] main_insn, skid_insn, main_d_insn;

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign acc_in    = in_valid & in_ready_q;
    assign acc_out   = out_valid & out_ready;

    // State register plus a dedicated in_ready flop, so in_ready never
    // depends combinationally on out_ready or flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != TWO);
        end
    end

    // Next-state logic; flush overrides every handshake.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: if (acc_in) state_d = ONE;
                ONE: begin
                    if (acc_in && !acc_out)      state_d = TWO;
                    else if (!acc_in && acc_out) state_d = EMPTY;
                end
                TWO:   if (acc_out) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    // Entry load controls. In TWO the skid is the only legal source for MAIN
    // because in_ready is low there.
    always_comb begin
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = (state_q == TWO);
        if (!flush) begin
            unique case (state_q)
                EMPTY: load_main = acc_in;
                ONE: begin
                    load_main = acc_in & acc_out;
                    load_skid = acc_in & ~acc_out;
                end
                TWO:   load_main = acc_out;
                default: load_main = 1'b0;
            endcase
        end
    end

    assign main_d_lane_vld = main_from_skid ? skid_lane_vld : in_lane_vld;
    assign main_d_pc       = main_from_skid ? skid_pc       : in_pc;
    assign main_d_insn     = main_from_skid ? skid_insn     : in_insn;

    pipe_stage_entry #(
        .LANES(LANES), .PC_W(PC_W), .INSN_W(INSN_W), .NOP_INSN(NOP_INSN)
    ) u_main (
        .clk(clk), .rst_n(rst_n), .load(load_main),
        .d_lane_vld(main_d_lane_vld), .d_pc(main_d_pc), .d_insn(main_d_insn),
        .q_lane_vld(main_lane_vld), .q_pc(main_pc), .q_insn(main_insn)
    );

    pipe_stage_entry #(
        .LANES(LANES), .PC_W(PC_W), .INSN_W(INSN_W), .NOP_INSN(NOP_INSN)
    ) u_skid (
        .clk(clk), .rst_n(rst_n), .load(load_skid),
        .d_lane_vld(in_lane_vld), .d_pc(in_pc), .d_insn(in_insn),
        .q_lane_vld(skid_lane_vld), .q_pc(skid_pc), .q_insn(skid_insn)
    );

    // MAIN keeps its payload after a flush or drain, so the visible lanes are
    // masked here instead; out_pc deliberately shows the last held pc.
    always_comb begin
        out_pc       = main_pc;
        out_lane_vld = '0;
        out_insn     = {LANES{NOP_INSN}};
        if (out_valid) begin
            out_lane_vld = main_lane_vld;
            out_insn     = main_insn;
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    // Saturating counters: stalled output cycles and flush cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_cnt != 32'hFFFFFFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (flush && (flush_cnt != 32'hFFFFFFFF)) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
